// File: rtl/ring_osc_bank_ctrl.sv
// Per-channel ring-oscillator enable controller: each channel runs its ring for a
// programmed number of clock cycles after a time-stamp strobe edge; RE freezes all rings.
module ring_osc_bank_ctrl #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [N_CH-1:0]   tsc_i,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic              RE,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [N_CH-1:0]   ring_en_o,
  output logic [N_CH-1:0]   done_o,
  output logic [N_CH-1:0]   busy_o,
  output logic              wr_err_o,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [2*N_CH-1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [N_CH-1:0]  tsc_q;

  logic             wr_ch_ok;
  logic             rd_ch_ok;
  logic [N_CH-1:0]  wr_sel;
  logic [N_CH-1:0]  wr_acc_d;
  logic [N_CH-1:0]  tsc_rise;
  logic [N_CH-1:0]  in_run;
  logic             wr_err_d;

  // Channel indices beyond N_CH only exist when N_CH is not a power of two.
  if (N_CH < (1 << CH_W)) begin : g_idx_chk
    assign wr_ch_ok = (wr_ch < CH_W'(N_CH));
    assign rd_ch_ok = (rd_ch < CH_W'(N_CH));
  end else begin : g_idx_full
    assign wr_ch_ok = 1'b1;
    assign rd_ch_ok = 1'b1;
  end

  // wr_en is a one-cycle command with no back-pressure: it is either applied at the
  // sampling edge or rejected, and a rejection shows on wr_err_o in the following cycle.
  always_comb begin
    in_run      = '0;
    wr_sel      = '0;
    wr_acc_d    = '0;
    tsc_rise    = '0;
    ring_en_o   = '0;
    busy_o      = '0;
    state_dbg_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_run[i]               = (state_q[i] == ST_RUN);
      wr_sel[i]               = wr_en && wr_ch_ok && (wr_ch == CH_W'(i));
      wr_acc_d[i]             = wr_sel[i] && !in_run[i];
      tsc_rise[i]             = tsc_i[i] && !tsc_q[i];
      ring_en_o[i]            = in_run[i] && !RE;
      busy_o[i]               = (state_q[i] == ST_ARMED) || in_run[i];
      state_dbg_o[2*i +: 2]   = state_q[i];
    end
    wr_err_d = wr_en && (!wr_ch_ok || |(wr_sel & in_run));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      tsc_q    <= '0;
      done_o   <= '0;
      wr_err_o <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      tsc_q    <= tsc_i;
      done_o   <= '0;
      wr_err_o <= wr_err_d;
      rd_valid <= RE;
      if (RE) begin
        rd_data <= rd_ch_ok ? cnt_q[rd_ch] : '0;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (wr_acc_d[i]) begin
          // A write beats a coinciding strobe edge; a zero budget completes at once.
          cnt_q[i] <= wr_data;
          if (wr_data == '0) begin
            state_q[i] <= ST_DONE;
            done_o[i]  <= 1'b1;
          end else begin
            state_q[i] <= ST_ARMED;
          end
        end else begin
          case (state_q[i])
            ST_ARMED: begin
              if (tsc_rise[i]) state_q[i] <= ST_RUN;
            end
            ST_RUN: begin
              if (!RE) begin
                if (cnt_q[i] <= CNT_W'(1)) begin
                  cnt_q[i]   <= '0;
                  state_q[i] <= ST_DONE;
                  done_o[i]  <= 1'b1;
                end else begin
                  cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
